// File: rtl/no_samples_in_counter.sv
// Input-sample counter for the FFT front end: counts accepted samples per
// frame, strobes per sample and on frame completion.
// Ports: clk, n_reset (sync, active-low), input_ena (sample valid),
//   iter_strobe (frame complete pulse), it_count_strobe (per-sample pulse),
//   samples_in_count_out (samples in current frame, 0..N_SAMPLES).
// Macro NO_SAMPLES_EDGE_DETECT_EN: accept only on 0->1 edges of input_ena.
`default_nettype none

module no_samples_in_counter #(
  parameter int N_SAMPLES = 64,
  parameter int COUNT_W   = 7
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               input_ena,
  output logic               iter_strobe,
  output logic               it_count_strobe,
  output logic [COUNT_W-1:0] samples_in_count_out
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(N_SAMPLES - 1);
  localparam logic [COUNT_W-1:0] FULL = COUNT_W'(N_SAMPLES);
  localparam logic [COUNT_W-1:0] ONE  = COUNT_W'(1);

  logic               accept;
  logic               frame_full;
  logic               frame_full_nxt;
  logic               iter_nxt;
  logic [COUNT_W-1:0] count_nxt;

`ifdef NO_SAMPLES_EDGE_DETECT_EN
  // Resets high so a level already asserted at reset release is ignored.
  logic ena_prev;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ena_prev <= 1'b1;
    end else begin
      ena_prev <= input_ena;
    end
  end

  assign accept = input_ena & ~ena_prev;
`else
  assign accept = input_ena;
`endif

  always_comb begin
    count_nxt      = samples_in_count_out;
    frame_full_nxt = frame_full;
    iter_nxt       = 1'b0;
    if (accept) begin
      unique case (1'b1)
        frame_full: begin
          // First sample of a new frame.
          count_nxt      = ONE;
          frame_full_nxt = 1'b0;
        end
        (samples_in_count_out == LAST): begin
          count_nxt      = FULL;
          frame_full_nxt = 1'b1;
          iter_nxt       = 1'b1;
        end
        default: begin
          count_nxt = samples_in_count_out + ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      samples_in_count_out <= '0;
      frame_full           <= 1'b0;
      iter_strobe          <= 1'b0;
      it_count_strobe      <= 1'b0;
    end else begin
      samples_in_count_out <= count_nxt;
      frame_full           <= frame_full_nxt;
      iter_strobe          <= iter_nxt;
      it_count_strobe      <= accept;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_no_samples_in_counter.sv
// Directed self-checking bench for no_samples_in_counter.
// Runs in level mode, or edge mode when NO_SAMPLES_EDGE_DETECT_EN is set.
`timescale 1ns/1ps

module tb_no_samples_in_counter;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       input_ena = 1'b0;
  logic       iter_strobe;
  logic       it_count_strobe;
  logic [6:0] samples_in_count_out;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  no_samples_in_counter #(
    .N_SAMPLES(64),
    .COUNT_W(7)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .input_ena(input_ena),
    .iter_strobe(iter_strobe),
    .it_count_strobe(it_count_strobe),
    .samples_in_count_out(samples_in_count_out)
  );

  // Apply one clock with the given enable; outputs settle 1 ns later.
  task automatic step(input logic ena);
    input_ena = ena;
    @(posedge clk);
    #1;
  endtask

  // Accept n samples using a 0,1 pattern valid in both modes.
  task automatic accept_n(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    step(1'b0);
    step(1'b0);
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    step(1'bx);
    step(1'b0);
    compared++;
    if (samples_in_count_out !== 7'd0) begin
      mismatched++;
      $display("FAIL reset_count: got %0d expected 0", samples_in_count_out);
    end
    compared++;
    if (it_count_strobe !== 1'b0 || iter_strobe !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_strobes: got %b%b expected 00",
               it_count_strobe, iter_strobe);
    end
    n_reset = 1'b1;
    step(1'b0);
    compared++;
    if (samples_in_count_out !== 7'd0 || it_count_strobe !== 1'b0
        || iter_strobe !== 1'b0) begin
      mismatched++;
      $display("FAIL release_idle: got cnt=%0d s=%b%b expected 0 00",
               samples_in_count_out, it_count_strobe, iter_strobe);
    end
  endtask

  task automatic test_alternating();
    int exp_cnt = 0;
    int n_strobe = 0;
    int n_iter = 0;
    logic exp_iter;
    for (int i = 1; i <= 100; i++) begin
      step(1'b0);
      compared++;
      if (it_count_strobe !== 1'b0 || iter_strobe !== 1'b0
          || samples_in_count_out !== 7'(exp_cnt)) begin
        mismatched++;
        $display("FAIL alt_low %0d: got cnt=%0d s=%b%b expected %0d 00", i,
                 samples_in_count_out, it_count_strobe, iter_strobe, exp_cnt);
      end
      step(1'b1);
      exp_cnt = (exp_cnt == 64) ? 1 : exp_cnt + 1;
      exp_iter = (exp_cnt == 64);
      if (it_count_strobe === 1'b1) n_strobe++;
      if (iter_strobe === 1'b1) n_iter++;
      compared++;
      if (samples_in_count_out !== 7'(exp_cnt) || iter_strobe !== exp_iter
          || it_count_strobe !== 1'b1) begin
        mismatched++;
        $display("FAIL alt_high %0d: got cnt=%0d s=%b%b expected %0d 1%b", i,
                 samples_in_count_out, it_count_strobe, iter_strobe,
                 exp_cnt, exp_iter);
      end
    end
    compared++;
    if (samples_in_count_out !== 7'd36) begin
      mismatched++;
      $display("FAIL alt_final: got %0d expected 36", samples_in_count_out);
    end
    compared++;
    if (n_strobe != 100 || n_iter != 1) begin
      mismatched++;
      $display("FAIL alt_pulses: got %0d/%0d expected 100/1", n_strobe, n_iter);
    end
  endtask

`ifndef NO_SAMPLES_EDGE_DETECT_EN
  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      step(1'b1);
      compared++;
      if (samples_in_count_out !== 7'(i) || it_count_strobe !== 1'b1
          || iter_strobe !== (i == 64)) begin
        mismatched++;
        $display("FAIL b2b %0d: got cnt=%0d s=%b%b expected %0d 1%b", i,
                 samples_in_count_out, it_count_strobe, iter_strobe, i,
                 (i == 64));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      compared++;
      if (samples_in_count_out !== 7'd64 || it_count_strobe !== 1'b0
          || iter_strobe !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_hold: got cnt=%0d s=%b%b expected 64 00",
                 samples_in_count_out, it_count_strobe, iter_strobe);
      end
    end
    step(1'b1);
    compared++;
    if (samples_in_count_out !== 7'd1 || iter_strobe !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_newframe: got cnt=%0d it=%b expected 1 0",
               samples_in_count_out, iter_strobe);
    end
  endtask
`else
  task automatic test_edge_detect();
    int n_strobe = 0;
    do_reset();
    step(1'b0);
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      if (it_count_strobe === 1'b1) n_strobe++;
    end
    compared++;
    if (samples_in_count_out !== 7'd1) begin
      mismatched++;
      $display("FAIL edge_count: got %0d expected 1", samples_in_count_out);
    end
    compared++;
    if (n_strobe != 1) begin
      mismatched++;
      $display("FAIL edge_pulses: got %0d expected 1", n_strobe);
    end
    // High through reset release must not count.
    n_reset = 1'b0;
    step(1'b1);
    n_reset = 1'b1;
    step(1'b1);
    step(1'b1);
    compared++;
    if (samples_in_count_out !== 7'd0 || it_count_strobe !== 1'b0) begin
      mismatched++;
      $display("FAIL edge_release: got cnt=%0d s=%b expected 0 0",
               samples_in_count_out, it_count_strobe);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    do_reset();
    accept_n(20);
    compared++;
    if (samples_in_count_out !== 7'd20) begin
      mismatched++;
      $display("FAIL mid_pre: got %0d expected 20", samples_in_count_out);
    end
    n_reset = 1'b0;
    step(1'b1);
    compared++;
    if (samples_in_count_out !== 7'd0 || it_count_strobe !== 1'b0
        || iter_strobe !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got cnt=%0d s=%b%b expected 0 00",
               samples_in_count_out, it_count_strobe, iter_strobe);
    end
    n_reset = 1'b1;
    step(1'b0);
    step(1'b1);
    compared++;
    if (samples_in_count_out !== 7'd1 || it_count_strobe !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_resume: got cnt=%0d s=%b expected 1 1",
               samples_in_count_out, it_count_strobe);
    end
  endtask

  task automatic test_idle_hold();
    accept_n(4);
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      compared++;
      if (samples_in_count_out !== 7'd5 || it_count_strobe !== 1'b0
          || iter_strobe !== 1'b0) begin
        mismatched++;
        $display("FAIL idle %0d: got cnt=%0d s=%b%b expected 5 00", i,
                 samples_in_count_out, it_count_strobe, iter_strobe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
`ifndef NO_SAMPLES_EDGE_DETECT_EN
    test_back_to_back();
`else
    test_edge_detect();
`endif
    test_reset_mid_frame();
    test_idle_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
